// File: rtl/mm_pkg.sv
// Shared widths, FSM encoding and byte-lane slice helper for the MXU skew feeder.
package mm_pkg;
    localparam int unsigned LANES  = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned WAVE_W = 5;
    localparam int unsigned ROW_W  = LANES * DW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FEED = 2'd2
    } state_e;

    // Byte k of a packed row: bits [DW*k+DW-1 : DW*k].
    function automatic logic [DW-1:0] byte_lane(input logic [ROW_W-1:0] row,
                                                input logic [LEN_W-1:0] k);
        return row[32'(k) * DW +: DW];
    endfunction
endpackage

// File: rtl/mm_skew_lane_sel.sv
// One lane of the diagonal wavefront: window compare on wave index and byte select.
module mm_skew_lane_sel
    import mm_pkg::*;
(
    input  logic [WAVE_W-1:0] i_t,
    input  logic [LEN_W-1:0]  i_lane,
    input  logic [LEN_W-1:0]  i_row_len,
    input  logic [LEN_W-1:0]  i_col_len,
    input  logic [ROW_W-1:0]  i_entry,
    output logic              o_vld,
    output logic [DW-1:0]     o_byte
);
    logic [WAVE_W-1:0] w_off;
    logic              w_in_win;

    // Offset is only meaningful once the wave has reached this lane.
    assign w_off    = i_t - WAVE_W'(i_lane);
    assign w_in_win = (i_lane <= i_row_len) &&
                      (i_t >= WAVE_W'(i_lane)) &&
                      (w_off <= WAVE_W'(i_col_len));

    assign o_vld  = w_in_win;
    assign o_byte = w_in_win ? byte_lane(i_entry, w_off[LEN_W-1:0]) : '0;
endmodule

// File: rtl/mm_mxu_skew_feeder.sv
// Captures operand rows from the LSU buffer and replays them to the MXU as a
// skewed wavefront (lane r delayed by r cycles), with stall and flush.
module mm_mxu_skew_feeder
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_vld,
    output logic              cfg_rdy,
    input  logic [LEN_W-1:0]  cfg_row_len,
    input  logic [LEN_W-1:0]  cfg_col_len,
    input  logic              row_vld,
    input  logic [LEN_W-1:0]  row_idx,
    input  logic [ROW_W-1:0]  row_data,
    input  logic              mxu_stall,
    input  logic              flush,
    output logic [LANES-1:0]  mxu_vld,
    output logic [ROW_W-1:0]  mxu_data,
    output logic              mxu_last,
    output logic              done
);
    state_e            r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_row_len, r_col_len;
    logic [LANES-1:0]  r_mask, w_mask_set, w_len_mask;
    logic [WAVE_W-1:0] r_t, w_t_last;
    logic [ROW_W-1:0]  r_entry [LANES];
    logic              r_cfg_rdy, r_done;
    logic              w_row_wr, w_load_done, w_feed, w_at_last, w_accept_last;
    logic [LANES-1:0]  w_lane_vld;
    logic [ROW_W-1:0]  w_lane_data;

    assign w_len_mask    = {LANES{1'b1}} >> (LEN_W'(LANES - 1) - r_row_len);
    assign w_row_wr      = (r_state == ST_LOAD) && row_vld && !flush && (row_idx <= r_row_len);
    assign w_mask_set    = w_row_wr ? (LANES'(1) << row_idx) : '0;
    // Completing beat counts toward the all-rows-present check.
    assign w_load_done   = &(r_mask | w_mask_set | ~w_len_mask);
    assign w_t_last      = WAVE_W'(r_row_len) + WAVE_W'(r_col_len);
    assign w_feed        = (r_state == ST_FEED);
    assign w_at_last     = w_feed && (r_t == w_t_last);
    assign w_accept_last = w_at_last && !mxu_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cfg_rdy <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_rdy <= (w_state_nxt == ST_IDLE);
            r_done    <= w_accept_last && !flush;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (cfg_vld)       w_state_nxt = ST_LOAD;
                ST_LOAD: if (w_load_done)   w_state_nxt = ST_FEED;
                ST_FEED: if (w_accept_last) w_state_nxt = ST_IDLE;
                default:                    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Job lengths, row-present mask and wave counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_len <= '0;
            r_col_len <= '0;
            r_mask    <= '0;
            r_t       <= '0;
        end else if (flush) begin
            r_mask <= '0;
            r_t    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (cfg_vld) begin
                    r_row_len <= cfg_row_len;
                    r_col_len <= cfg_col_len;
                    r_mask    <= '0;
                    r_t       <= '0;
                end
                ST_LOAD: r_mask <= r_mask | w_mask_set;
                ST_FEED: if (!mxu_stall) r_t <= w_accept_last ? '0 : r_t + WAVE_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_row_wr) r_entry[row_idx] <= row_data;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mm_skew_lane_sel u_sel (
            .i_t       (r_t),
            .i_lane    (LEN_W'(g)),
            .i_row_len (r_row_len),
            .i_col_len (r_col_len),
            .i_entry   (r_entry[g]),
            .o_vld     (w_lane_vld[g]),
            .o_byte    (w_lane_data[g*DW +: DW])
        );
    end

    assign mxu_vld  = w_feed ? w_lane_vld  : '0;
    assign mxu_data = w_feed ? w_lane_data : '0;
    assign mxu_last = w_at_last;
    assign cfg_rdy  = r_cfg_rdy;
    assign done     = r_done;
endmodule

// File: tb/tb_mm_mxu_skew_feeder.sv
// Directed bench for the MXU skew feeder: waves, stall, duplicate/dropped rows, flush, reset.
module tb_mm_mxu_skew_feeder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_vld, cfg_rdy;
    logic [3:0]   cfg_row_len, cfg_col_len;
    logic         row_vld;
    logic [3:0]   row_idx;
    logic [127:0] row_data;
    logic         mxu_stall, flush;
    logic [15:0]  mxu_vld;
    logic [127:0] mxu_data;
    logic         mxu_last, done;

    int checks = 0;
    int errors = 0;
    int waves, done_cyc;
    logic [15:0]  cap_vld  [32];
    logic [127:0] cap_data [32];
    logic         cap_last [32];
    logic [127:0] d;

    always #5 clk = ~clk;

    mm_mxu_skew_feeder dut (
        .clk(clk), .rst_n(rst_n), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
        .cfg_row_len(cfg_row_len), .cfg_col_len(cfg_col_len),
        .row_vld(row_vld), .row_idx(row_idx), .row_data(row_data),
        .mxu_stall(mxu_stall), .flush(flush), .mxu_vld(mxu_vld),
        .mxu_data(mxu_data), .mxu_last(mxu_last), .done(done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int r);
        logic [127:0] p;
        for (int k = 0; k < 16; k++) p[k*8 +: 8] = 8'(16 * r + k);
        return p;
    endfunction

    task automatic cfg(input logic [3:0] rl, input logic [3:0] cl);
        cfg_vld = 1'b1; cfg_row_len = rl; cfg_col_len = cl;
        tick();
        cfg_vld = 1'b0;
    endtask

    task automatic load_row(input logic [3:0] idx, input logic [127:0] data);
        row_vld = 1'b1; row_idx = idx; row_data = data;
        tick();
        row_vld = 1'b0;
    endtask

    // Consume waves until done, optionally stalling one wave; bounded by a cycle budget.
    task automatic run_feed(input int stall_at, input int stall_cycles);
        int stalled;
        logic [15:0]  sv;
        logic [127:0] sd;
        waves = 0; done_cyc = -1; stalled = 0; sv = '0; sd = '0;
        for (int c = 0; c < 80; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (mxu_vld != 16'h0) begin
                if (waves == stall_at && stalled < stall_cycles) begin
                    if (stalled == 0) begin
                        sv = mxu_vld; sd = mxu_data;
                    end else begin
                        chk("stall_vld_hold", 128'(mxu_vld), 128'(sv));
                        chk("stall_data_hold", mxu_data, sd);
                    end
                    mxu_stall = 1'b1;
                    stalled++;
                end else begin
                    if (stalled > 0 && waves == stall_at) begin
                        chk("stall_release_vld", 128'(mxu_vld), 128'(sv));
                        chk("stall_release_data", mxu_data, sd);
                    end
                    mxu_stall = 1'b0;
                    cap_vld[waves] = mxu_vld; cap_data[waves] = mxu_data; cap_last[waves] = mxu_last;
                    waves++;
                end
            end
            tick();
        end
        mxu_stall = 1'b0;
    endtask

    task automatic job1(input int stall_at, input int stall_cycles);
        cfg(4'd3, 4'd3);
        for (int r = 0; r < 4; r++) load_row(4'(r), pat(r));
        run_feed(stall_at, stall_cycles);
    endtask

    task automatic check_job1(input int exp_done);
        chk("j1_waves", 128'(waves), 128'(7));
        chk("j1_t0_vld", 128'(cap_vld[0]), 128'h0001);
        chk("j1_t0_data", cap_data[0], 128'h0);
        chk("j1_t3_vld", 128'(cap_vld[3]), 128'h000F);
        chk("j1_t3_data", cap_data[3], 128'h30211203);
        chk("j1_t5_last", 128'(cap_last[5]), 128'h0);
        chk("j1_t6_vld", 128'(cap_vld[6]), 128'h0008);
        chk("j1_t6_data", cap_data[6], 128'h33000000);
        chk("j1_t6_last", 128'(cap_last[6]), 128'h1);
        chk("j1_done_cyc", 128'(done_cyc), 128'(exp_done));
        chk("j1_rdy_at_done", 128'(cfg_rdy), 128'h1);
        chk("j1_vld_at_done", 128'(mxu_vld), 128'h0);
        tick();
        chk("j1_done_pulse", 128'(done), 128'h0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_vld = 1'b0; cfg_row_len = '0; cfg_col_len = '0;
        row_vld = 1'b0; row_idx = '0; row_data = '0; mxu_stall = 1'b0; flush = 1'b0;
        #12;
        chk("rst_cfg_rdy", 128'(cfg_rdy), 128'h1);
        chk("rst_mxu_vld", 128'(mxu_vld), 128'h0);
        chk("rst_mxu_data", mxu_data, 128'h0);
        chk("rst_last", 128'(mxu_last), 128'h0);
        chk("rst_done", 128'(done), 128'h0);
        rst_n = 1'b1;
        tick();

        // 1: 4x4 job in order
        job1(-1, 0);
        check_job1(7);

        // 2: 16x16 job, rows delivered in reverse
        cfg(4'd15, 4'd15);
        for (int r = 15; r >= 1; r--) load_row(4'(r), pat(r));
        chk("j2_load_rdy", 128'(cfg_rdy), 128'h0);
        chk("j2_load_vld", 128'(mxu_vld), 128'h0);
        load_row(4'd0, pat(0));
        run_feed(-1, 0);
        chk("j2_waves", 128'(waves), 128'(31));
        chk("j2_t15_vld", 128'(cap_vld[15]), 128'hFFFF);
        d = cap_data[15];
        chk("j2_t15_lane0", 128'(d[7:0]), 128'h0F);
        chk("j2_t15_lane15", 128'(d[127:120]), 128'hF0);
        chk("j2_t30_vld", 128'(cap_vld[30]), 128'h8000);
        chk("j2_t30_data", cap_data[30], {8'hFF, 120'h0});
        chk("j2_done_cyc", 128'(done_cyc), 128'(31));
        tick();

        // 3: job 1 with a 3-cycle stall at t=2
        job1(2, 3);
        check_job1(10);

        // 4: dropped out-of-range row and duplicate overwrite
        cfg(4'd1, 4'd1);
        load_row(4'd5, {16{8'h77}});
        load_row(4'd0, {16{8'h55}});
        chk("j4_still_load_rdy", 128'(cfg_rdy), 128'h0);
        chk("j4_still_load_vld", 128'(mxu_vld), 128'h0);
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(8'hA0 + k);
        load_row(4'd0, d);
        chk("j4_dup_still_load", 128'(mxu_vld), 128'h0);
        load_row(4'd1, pat(1));
        run_feed(-1, 0);
        chk("j4_waves", 128'(waves), 128'(3));
        chk("j4_t0_data", cap_data[0], 128'hA0);
        chk("j4_t1_vld", 128'(cap_vld[1]), 128'h0003);
        chk("j4_t1_data", cap_data[1], 128'h10A1);
        chk("j4_t2_data", cap_data[2], 128'h1100);
        chk("j4_done_cyc", 128'(done_cyc), 128'(3));
        tick();

        // 5: flush at t=2 with a simultaneous cfg_vld
        cfg(4'd3, 4'd3);
        for (int r = 0; r < 4; r++) load_row(4'(r), pat(r));
        tick(); tick();
        chk("j5_t2_vld", 128'(mxu_vld), 128'h0007);
        flush = 1'b1; cfg_vld = 1'b1; cfg_row_len = 4'd0; cfg_col_len = 4'd0;
        tick();
        flush = 1'b0; cfg_vld = 1'b0;
        chk("j5_flush_rdy", 128'(cfg_rdy), 128'h1);
        chk("j5_flush_vld", 128'(mxu_vld), 128'h0);
        chk("j5_flush_done", 128'(done), 128'h0);
        tick();
        chk("j5_flush_done2", 128'(done), 128'h0);
        cfg(4'd1, 4'd0);
        load_row(4'd0, pat(0));
        chk("j5_fresh_load", 128'(cfg_rdy), 128'h0);
        chk("j5_fresh_load_vld", 128'(mxu_vld), 128'h0);
        load_row(4'd1, pat(1));
        run_feed(-1, 0);
        chk("j5_waves", 128'(waves), 128'(2));
        chk("j5_t1_vld", 128'(cap_vld[1]), 128'h0002);
        chk("j5_t1_data", cap_data[1], 128'h1000);
        chk("j5_done_cyc", 128'(done_cyc), 128'(2));
        tick();

        // 6: async reset during LOAD, then job 1 again
        cfg(4'd3, 4'd3);
        load_row(4'd0, pat(0));
        load_row(4'd1, pat(1));
        chk("j6_pre_rdy", 128'(cfg_rdy), 128'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("j6_rst_rdy", 128'(cfg_rdy), 128'h1);
        chk("j6_rst_vld", 128'(mxu_vld), 128'h0);
        chk("j6_rst_done", 128'(done), 128'h0);
        #1 rst_n = 1'b1;
        tick();
        job1(-1, 0);
        check_job1(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
